// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader writing a framed program image into byte-lane program RAM
// Frame: 0xA5, CNT_HI, CNT_LO, NB_COL*CNT data bytes, 8-bit additive checksum.
module uart_prog_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int NB_COL       = 4,
  parameter int COL_WIDTH    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 2**20
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          uart_rxd,
  output logic [NB_COL-1:0]             mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   mem_wdata,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          load_err
);

  localparam int LANE_W = $clog2(NB_COL);
  localparam int IDX_W  = 16 + LANE_W;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;

  logic            rxd_s1, rxd_s2, rxd_d;
  rx_state_t       rx_state, rx_state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            rx_valid, rx_ferr;
  logic            bit_end, half_end, fall;

  state_t          state, state_next;
  logic [7:0]      hi_byte;
  logic [15:0]     word_cnt;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]      sum;
  logic [TO_W-1:0] idle_cnt;
  logic            timeout, last_byte;
  logic            do_write, set_done, set_err, start_frame;

  assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_end = (clk_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign fall     = rxd_d & ~rxd_s2;

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_state_next = RX_START;
      RX_START: if (half_end) rx_state_next = rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_cnt == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (bit_end) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // Sample counter restarts on every state change so data bits are timed from mid-start-bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_d    <= 1'b1;
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_d    <= rxd_s2;
      rx_state <= rx_state_next;
      if (rx_state == RX_IDLE || rx_state_next != rx_state || bit_end)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + CNT_W'(1);
      if (rx_state == RX_START)
        bit_cnt <= '0;
      else if (rx_state == RX_DATA && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_byte <= {rxd_s2, rx_byte[7:1]};
      end
      rx_valid <= (rx_state == RX_STOP) && bit_end && rxd_s2;
      rx_ferr  <= (rx_state == RX_STOP) && bit_end && !rxd_s2;
    end
  end

  assign load_busy = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CSUM);
  assign timeout   = load_busy && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CLKS - 1));
  assign last_byte = (byte_idx == {word_cnt, {LANE_W{1'b0}}} - IDX_W'(1));

  always_comb begin
    state_next  = state;
    do_write    = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    start_frame = 1'b0;
    if (timeout || (rx_ferr && load_busy)) begin
      state_next = ERR;
      set_err    = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE, DONE, ERR:
          if (rx_byte == SYNC_BYTE) begin
            state_next  = CNT_HI;
            start_frame = 1'b1;
          end
        CNT_HI: state_next = CNT_LO;
        CNT_LO: state_next = ({hi_byte, rx_byte} == 16'd0) ? CSUM : DATA;
        DATA: begin
          do_write = 1'b1;
          if (last_byte) state_next = CSUM;
        end
        CSUM:
          if (rx_byte == sum) begin
            state_next = DONE;
            set_done   = 1'b1;
          end else begin
            state_next = ERR;
            set_err    = 1'b1;
          end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hi_byte   <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      sum       <= '0;
      idle_cnt  <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (rx_valid || !load_busy)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TO_W'(1);
      if (rx_valid && state == CNT_HI)
        hi_byte <= rx_byte;
      if (rx_valid && state == CNT_LO) begin
        word_cnt <= {hi_byte, rx_byte};
        byte_idx <= '0;
        sum      <= '0;
      end
      mem_we <= do_write ? (NB_COL'(1) << byte_idx[LANE_W-1:0]) : '0;
      if (do_write) begin
        mem_addr  <= ADDR_WIDTH'(byte_idx >> LANE_W);
        mem_wdata <= {NB_COL{rx_byte}};
        byte_idx  <= byte_idx + IDX_W'(1);
        sum       <= sum + rx_byte;
      end
      if (start_frame) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      if (set_done) load_done <= 1'b1;
      if (set_err)  load_err  <= 1'b1;
    end
  end

endmodule
